// File: rtl/bp_me_stream_out_arbiter.sv
// Round-robin arbiter that shares one BedRock stream output among several producers.
// A message keeps the channel from its first accepted beat through its last accepted beat.
module bp_me_stream_out_arbiter #(
  parameter int num_req_p           = 2,
  parameter int stream_data_width_p = 64,
  parameter int payload_width_p     = 64,
  parameter int paddr_width_p       = 40,
  localparam int lg_req_lp          = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  // BedRock header: msg_type(4) + subop(4) + addr + size(3) + payload
  localparam int xce_header_width_lp = payload_width_p + paddr_width_p + 11
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,

  input  logic [num_req_p*xce_header_width_lp-1:0] in_header_i,
  input  logic [num_req_p*stream_data_width_p-1:0] in_data_i,
  input  logic [num_req_p-1:0]                     in_v_i,
  input  logic [num_req_p-1:0]                     in_last_i,
  output logic [num_req_p-1:0]                     in_ready_and_o,

  output logic [xce_header_width_lp-1:0]           msg_header_o,
  output logic [stream_data_width_p-1:0]           msg_data_o,
  output logic                                     msg_v_o,
  output logic                                     msg_last_o,
  input  logic                                     msg_ready_and_i,

  output logic [num_req_p-1:0]                     grant_o,
  output logic                                     lock_o
);

  typedef enum logic {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } state_e;

  state_e               state_r, state_n;
  logic [lg_req_lp-1:0] rr_ptr_r, rr_ptr_n;
  logic [lg_req_lp-1:0] lock_id_r, lock_id_n;
  logic [lg_req_lp-1:0] rr_sel, sel;
  logic                 rr_found;
  logic                 active;
  logic                 hs;

  // Wraps explicitly so a non-power-of-2 count never stores num_req_p.
  function automatic logic [lg_req_lp-1:0] next_id(input logic [lg_req_lp-1:0] id);
    if (int'(id) >= num_req_p - 1) return '0;
    else                           return id + lg_req_lp'(1);
  endfunction

  // Scan from rr_ptr_r upward; walking offsets high-to-low lets the lowest offset win.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    int idx;
    idx      = 0;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (in_v_i[idx[lg_req_lp-1:0]]) begin
        rr_sel   = idx[lg_req_lp-1:0];
        rr_found = 1'b1;
      end
    end
  end

  assign sel    = (state_r == e_locked) ? lock_id_r : rr_sel;
  // Reset gates the outputs combinationally so they drop without waiting for a clock edge.
  assign active = ~reset_i & ((state_r == e_locked) | rr_found);

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      grant_o[i] = active & (sel == lg_req_lp'(i));
    end
  end

  assign msg_v_o        = active & in_v_i[sel];
  assign msg_last_o     = in_last_i[sel];
  assign msg_header_o   = in_header_i[int'(sel)*xce_header_width_lp +: xce_header_width_lp];
  assign msg_data_o     = in_data_i[int'(sel)*stream_data_width_p +: stream_data_width_p];
  assign in_ready_and_o = grant_o & {num_req_p{msg_ready_and_i}};
  assign lock_o         = (state_r == e_locked);
  assign hs             = msg_v_o & msg_ready_and_i;

  always_comb begin
    state_n   = state_r;
    rr_ptr_n  = rr_ptr_r;
    lock_id_n = lock_id_r;
    unique case (state_r)
      e_idle: begin
        if (hs) begin
          if (msg_last_o) begin
            rr_ptr_n = next_id(sel);
          end else begin
            state_n   = e_locked;
            lock_id_n = sel;
          end
        end
      end
      e_locked: begin
        if (hs && msg_last_o) begin
          state_n  = e_idle;
          rr_ptr_n = next_id(lock_id_r);
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= e_idle;
      rr_ptr_r  <= '0;
      lock_id_r <= '0;
    end else begin
      state_r   <= state_n;
      rr_ptr_r  <= rr_ptr_n;
      lock_id_r <= lock_id_n;
    end
  end

`ifndef SYNTHESIS
  grant_onehot0_a: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_o));

  for (genvar i = 0; i < num_req_p; i++) begin : g_v_hold
    v_hold_a: assert property (@(posedge clk_i) disable iff (reset_i)
      (in_v_i[i] && !in_ready_and_o[i]) |=> in_v_i[i]);
  end
`endif

endmodule

// File: tb/tb_bp_me_stream_out_arbiter.sv
// Bench for bp_me_stream_out_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a round-robin/lock reference model.
module tb_bp_me_stream_out_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int AW = 12;
  localparam int HW = PW + AW + 11;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*HW-1:0] in_header;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_v, in_last, in_ready, grant;
  logic [HW-1:0]   msg_header;
  logic [DW-1:0]   msg_data;
  logic            msg_v, msg_last, msg_ready, lock;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bp_me_stream_out_arbiter #(
    .num_req_p          (N),
    .stream_data_width_p(DW),
    .payload_width_p    (PW),
    .paddr_width_p      (AW)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .in_header_i    (in_header),
    .in_data_i      (in_data),
    .in_v_i         (in_v),
    .in_last_i      (in_last),
    .in_ready_and_o (in_ready),
    .msg_header_o   (msg_header),
    .msg_data_o     (msg_data),
    .msg_v_o        (msg_v),
    .msg_last_o     (msg_last),
    .msg_ready_and_i(msg_ready),
    .grant_o        (grant),
    .lock_o         (lock)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner of the channel (-1 when free) and round-robin start point.
  int own = -1;
  int rr  = 0;

  function automatic int model_sel();
    if (own >= 0) return own;
    for (int k = 0; k < N; k++) begin
      if (in_v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int s;
    logic ev;
    logic [N-1:0] eg;
    if (rst) begin
      check("m_rst_grant", 64'(grant), 64'(0));
      check("m_rst_v", 64'(msg_v), 64'(0));
      check("m_rst_lock", 64'(lock), 64'(0));
      check("m_rst_ready", 64'(in_ready), 64'(0));
      own = -1;
      rr  = 0;
    end else begin
      s  = model_sel();
      eg = '0;
      if (s >= 0) eg[s] = 1'b1;
      ev = (s >= 0) && in_v[s];
      check("m_grant", 64'(grant), 64'(eg));
      check("m_v", 64'(msg_v), 64'(ev));
      check("m_lock", 64'(lock), 64'(own >= 0));
      check("m_ready", 64'(in_ready), 64'(msg_ready ? eg : '0));
      if (ev) begin
        check("m_header", 64'(msg_header), 64'(in_header[s*HW +: HW]));
        check("m_data", 64'(msg_data), 64'(in_data[s*DW +: DW]));
        check("m_last", 64'(msg_last), 64'(in_last[s]));
        if (msg_ready) begin
          if (in_last[s]) begin
            own = -1;
            rr  = (s + 1) % N;
          end else begin
            own = s;
          end
        end
      end
    end
  end

  task automatic drive(input int i, input logic v, input logic last, input logic [DW-1:0] d);
    logic [3:0] tag;
    tag = 4'(i);
    in_v[i]               = v;
    in_last[i]            = last;
    in_data[i*DW +: DW]   = d;
    in_header[i*HW +: HW] = HW'({tag, d ^ 16'h5a5a});
  endtask

  task automatic idle_all();
    in_v    = '0;
    in_last = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input logic v,
                            input logic lk, input logic [N-1:0] rdy);
    #1;
    check({name, "_grant"}, 64'(grant), 64'(g));
    check({name, "_v"}, 64'(msg_v), 64'(v));
    check({name, "_lock"}, 64'(lock), 64'(lk));
    check({name, "_ready"}, 64'(in_ready), 64'(rdy));
  endtask

  initial begin
    int beat[N];
    int len[N];
    int msgs[N];
    int exp_g[8];
    logic [N-1:0] acc;
    logic draining;
    bit done;

    rst       = 1'b1;
    msg_ready = 1'b1;
    in_header = '0;
    in_data   = '0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;

    // Valid input while reset is held must not reach the outputs.
    drive(0, 1'b1, 1'b0, 16'hA000);
    expect_out("rst_gate", 3'b000, 1'b0, 1'b0, 3'b000);
    rst = 1'b0;

    // 4-beat message from src0 alone.
    expect_out("t1_b0", 3'b001, 1'b1, 1'b0, 3'b001);
    check("t1_b0_data", 64'(msg_data), 64'(16'hA000));
    tick(); drive(0, 1'b1, 1'b0, 16'hA001);
    expect_out("t1_b1", 3'b001, 1'b1, 1'b1, 3'b001);
    check("t1_b1_data", 64'(msg_data), 64'(16'hA001));
    tick(); drive(0, 1'b1, 1'b0, 16'hA002);
    expect_out("t1_b2", 3'b001, 1'b1, 1'b1, 3'b001);
    tick(); drive(0, 1'b1, 1'b1, 16'hA003);
    expect_out("t1_b3", 3'b001, 1'b1, 1'b1, 3'b001);
    check("t1_b3_last", 64'(msg_last), 64'(1));
    tick(); drive(0, 1'b0, 1'b0, 16'h0000);
    expect_out("t1_done", 3'b000, 1'b0, 1'b0, 3'b000);
    // rr pointer now at src1: it wins even though src0 is also valid.
    drive(0, 1'b1, 1'b1, 16'hB000);
    drive(1, 1'b1, 1'b1, 16'hB100);
    expect_out("t1_rr", 3'b010, 1'b1, 1'b0, 3'b010);
    tick(); drive(1, 1'b0, 1'b0, 16'h0000);
    expect_out("t1_rr2", 3'b001, 1'b1, 1'b0, 3'b001);
    tick(); idle_all();

    // Two 2-beat messages per source, both always valid; pointer starts at src1.
    exp_g = '{2, 2, 1, 1, 2, 2, 1, 1};
    for (int i = 0; i < N; i++) begin beat[i] = 0; msgs[i] = 0; end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++)
        drive(i, msgs[i] < 2, beat[i] == 1, DW'(16'hC000 + i*256 + msgs[i]*16 + beat[i]));
      #1;
      check("t2_grant", 64'(grant), 64'(exp_g[k]));
      check("t2_no_bubble", 64'(msg_v), 64'(1));
      acc = in_v & in_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if (beat[i] == 1) begin beat[i] = 0; msgs[i]++; end
          else beat[i] = 1;
        end
      end
    end
    idle_all();

    // src0 locked, downstream stalls 3 cycles while src1 waits.
    drive(0, 1'b1, 1'b0, 16'hD000);
    expect_out("t3_b0", 3'b001, 1'b1, 1'b0, 3'b001);
    tick(); drive(0, 1'b1, 1'b0, 16'hD001); drive(1, 1'b1, 1'b1, 16'hD100);
    msg_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_out("t3_stall", 3'b001, 1'b1, 1'b1, 3'b000);
      tick();
    end
    msg_ready = 1'b1;
    expect_out("t3_go", 3'b001, 1'b1, 1'b1, 3'b001);
    tick(); drive(0, 1'b1, 1'b1, 16'hD002);
    expect_out("t3_last", 3'b001, 1'b1, 1'b1, 3'b001);
    tick(); drive(0, 1'b0, 1'b0, 16'h0000);
    expect_out("t3_src1", 3'b010, 1'b1, 1'b0, 3'b010);
    tick(); idle_all();

    // src1 locked, drops valid for 2 cycles after beat 2; src0 must not be served.
    drive(1, 1'b1, 1'b0, 16'hE100);
    expect_out("t5_b0", 3'b010, 1'b1, 1'b0, 3'b010);
    tick(); drive(1, 1'b1, 1'b0, 16'hE101);
    expect_out("t5_b1", 3'b010, 1'b1, 1'b1, 3'b010);
    tick(); drive(1, 1'b0, 1'b0, 16'h0000); drive(0, 1'b1, 1'b1, 16'hE000);
    for (int k = 0; k < 2; k++) begin
      expect_out("t5_gap", 3'b010, 1'b0, 1'b1, 3'b010);
      tick();
    end
    drive(1, 1'b1, 1'b0, 16'hE102);
    expect_out("t5_b2", 3'b010, 1'b1, 1'b1, 3'b010);
    check("t5_b2_data", 64'(msg_data), 64'(16'hE102));
    tick(); drive(1, 1'b1, 1'b1, 16'hE103);
    expect_out("t5_b3", 3'b010, 1'b1, 1'b1, 3'b010);
    tick(); drive(1, 1'b0, 1'b0, 16'h0000);
    expect_out("t5_src0", 3'b001, 1'b1, 1'b0, 3'b001);
    tick(); idle_all();

    // Reset asserted between clock edges in the middle of a message.
    drive(1, 1'b1, 1'b0, 16'hF100);
    expect_out("t6_b0", 3'b010, 1'b1, 1'b0, 3'b010);
    tick(); drive(1, 1'b1, 1'b0, 16'hF101);
    #1;
    rst = 1'b1;
    expect_out("t6_async", 3'b000, 1'b0, 1'b0, 3'b000);
    idle_all();
    tick(); tick();
    rst = 1'b0;

    // Three single-beat sources held valid: plain rotation from src0.
    for (int i = 0; i < N; i++) msgs[i] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) drive(i, msgs[i] < 2, 1'b1, DW'(16'h6000 + i*16 + k));
      expect_out("t4_rot", 3'(1 << (k % 3)), 1'b1, 1'b0, 3'(1 << (k % 3)));
      acc = in_v & in_ready;
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) msgs[i]++;
    end
    idle_all();

    // Random traffic: messages of 1-4 beats, valid held until accepted, random stalls.
    acc      = '0;
    draining = 1'b0;
    for (int i = 0; i < N; i++) begin beat[i] = 0; len[i] = $urandom_range(1, 4); end
    done = 1'b0;
    for (int c = 0; c < 3400 && !done; c++) begin
      if (c == 3000) draining = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          beat[i]++;
          if (beat[i] == len[i]) begin beat[i] = 0; len[i] = $urandom_range(1, 4); end
        end
        if (!(in_v[i] && !acc[i])) begin
          drive(i, (beat[i] != 0 || !draining) && ($urandom_range(0, 9) < 6),
                beat[i] == len[i] - 1, DW'($urandom));
        end
      end
      if (draining && in_v == '0 && beat[0] == 0 && beat[1] == 0 && beat[2] == 0) done = 1'b1;
      msg_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = in_v & in_ready;
      tick();
    end
    check("rand_drained", 64'(done), 64'(1));
    idle_all();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
